token_tracker: RTL and testbench

- Multi-channel, stateful successor to the combinational token decoder.
- Decodes the v/a/r bits of each channel's FTk_t. Tracks message and nested fragment (flagmsg) ownership per channel, counts data beats inside a message, and flags protocol violations.
- Sits between link inputs and the consuming units. Those units read per-channel busy/depth state instead of re-decoding raw tokens.

---
 rtl/token_tracker_if.sv | 42 ++++
 rtl/token_tracker.sv | 254 +++++++++++++++++++++++++
 tb/tb_token_tracker.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/token_tracker_if.sv
// Bundles the per-channel token inputs and the tracker status/pulse outputs.
// The slave modport belongs to token_tracker; the master modport belongs to whatever drives the links.
interface token_tracker_if #(
  parameter int NUM_CH  = 4,
  parameter int W_DEPTH = 2,
  parameter int W_CNT   = 16
);

  typedef struct packed {
    logic v;
    logic a;
    logic r;
  } FTk_t;

  FTk_t [NUM_CH-1:0]              I_FTk;
  logic [NUM_CH-1:0]              I_err_clr;
  logic [NUM_CH-1:0]              O_busy;
  logic [NUM_CH-1:0]              O_in_frag;
  logic [NUM_CH-1:0][W_DEPTH-1:0] O_frag_depth;
  logic [NUM_CH-1:0][W_CNT-1:0]   O_beat_cnt;
  logic [NUM_CH-1:0]              O_acq_message;
  logic [NUM_CH-1:0]              O_rls_message;
  logic [NUM_CH-1:0]              O_acq_flagmsg;
  logic [NUM_CH-1:0]              O_rls_flagmsg;
  logic [NUM_CH-1:0]              O_err;
  logic [NUM_CH-1:0][1:0]         O_err_code;

  modport master (
    output I_FTk, I_err_clr,
    input  O_busy, O_in_frag, O_frag_depth, O_beat_cnt,
    input  O_acq_message, O_rls_message, O_acq_flagmsg, O_rls_flagmsg,
    input  O_err, O_err_code
  );

  modport slave (
    input  I_FTk, I_err_clr,
    output O_busy, O_in_frag, O_frag_depth, O_beat_cnt,
    output O_acq_message, O_rls_message, O_acq_flagmsg, O_rls_flagmsg,
    output O_err, O_err_code
  );

endinterface

// File: rtl/token_tracker.sv
// Per-channel message/fragment ownership tracker with beat counting and sticky protocol errors.
// Optional idle-timeout abort of held channels is compiled in when TOKEN_TIMEOUT_EN is defined.
module token_tracker #(
  parameter int NUM_CH         = 4,
  parameter int MAX_FRAG_DEPTH = 3,
  parameter int W_DEPTH        = $clog2(MAX_FRAG_DEPTH + 1),
  parameter int W_CNT          = 16,
  parameter int TIMEOUT        = 1024
) (
  input  logic          clock,
  input  logic          reset,
  token_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MSG  = 2'd1,
    ST_FRAG = 2'd2
  } state_e;

  // The {a,r} pair maps directly onto the token kind.
  typedef enum logic [1:0] {
    K_DATA     = 2'b00,
    K_RLS_FRAG = 2'b01,
    K_ACQ      = 2'b10,
    K_RLS_MSG  = 2'b11
  } kind_e;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_NO_ACQ  = 2'd1;
  localparam logic [1:0] CODE_DEPTH   = 2'd2;
  localparam logic [1:0] CODE_OUTSIDE = 2'd3;

  localparam logic [W_DEPTH-1:0] DEPTH_MAX = W_DEPTH'(MAX_FRAG_DEPTH);
  localparam logic [W_DEPTH-1:0] DEPTH_ONE = W_DEPTH'(1);
  localparam logic [W_CNT-1:0]   BEAT_MAX  = {W_CNT{1'b1}};

  if (MAX_FRAG_DEPTH < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("token_tracker: MAX_FRAG_DEPTH and TIMEOUT must be >= 1");
  end

  state_e             state_q [NUM_CH];
  state_e             state_d [NUM_CH];
  logic [W_DEPTH-1:0] depth_q [NUM_CH];
  logic [W_DEPTH-1:0] depth_d [NUM_CH];
  logic [W_CNT-1:0]   beat_q  [NUM_CH];
  logic [W_CNT-1:0]   beat_d  [NUM_CH];
  logic [1:0]         code_q  [NUM_CH];
  logic [1:0]         code_d  [NUM_CH];
  logic [NUM_CH-1:0]  busy_q, busy_d;
  logic [NUM_CH-1:0]  frag_q, frag_d;
  logic [NUM_CH-1:0]  acq_msg_q, acq_msg_d;
  logic [NUM_CH-1:0]  rls_msg_q, rls_msg_d;
  logic [NUM_CH-1:0]  acq_frag_q, acq_frag_d;
  logic [NUM_CH-1:0]  rls_frag_q, rls_frag_d;
  logic [NUM_CH-1:0]  err_q, err_d;

  kind_e              kind_s  [NUM_CH];
  logic [NUM_CH-1:0]  viol_s;
  logic [1:0]         vcode_s [NUM_CH];

`ifdef TOKEN_TIMEOUT_EN
  localparam int W_TO = $clog2(TIMEOUT + 1);
  localparam logic [W_TO-1:0] TO_LAST = W_TO'(TIMEOUT - 1);
  logic [W_TO-1:0] idle_q [NUM_CH];
  logic [W_TO-1:0] idle_d [NUM_CH];
`endif

  // Next-state, counters, pulses and error latch for every channel.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c]    = state_q[c];
      depth_d[c]    = depth_q[c];
      beat_d[c]     = beat_q[c];
      err_d[c]      = err_q[c];
      code_d[c]     = code_q[c];
      acq_msg_d[c]  = 1'b0;
      rls_msg_d[c]  = 1'b0;
      acq_frag_d[c] = 1'b0;
      rls_frag_d[c] = 1'b0;
      viol_s[c]     = 1'b0;
      vcode_s[c]    = CODE_NONE;
      kind_s[c]     = kind_e'({bus.I_FTk[c].a, bus.I_FTk[c].r});
`ifdef TOKEN_TIMEOUT_EN
      idle_d[c]     = '0;
`endif

      if (bus.I_FTk[c].v) begin
        case (state_q[c])
          ST_IDLE: begin
            case (kind_s[c])
              K_ACQ: begin
                state_d[c]   = ST_MSG;
                beat_d[c]    = '0;
                acq_msg_d[c] = 1'b1;
              end
              K_RLS_MSG, K_RLS_FRAG: begin
                viol_s[c]  = 1'b1;
                vcode_s[c] = CODE_NO_ACQ;
              end
              default: begin
                viol_s[c]  = 1'b1;
                vcode_s[c] = CODE_OUTSIDE;
              end
            endcase
          end
          ST_MSG: begin
            case (kind_s[c])
              K_ACQ: begin
                state_d[c]    = ST_FRAG;
                depth_d[c]    = DEPTH_ONE;
                acq_frag_d[c] = 1'b1;
              end
              K_RLS_MSG: begin
                state_d[c]   = ST_IDLE;
                rls_msg_d[c] = 1'b1;
              end
              K_RLS_FRAG: begin
                viol_s[c]  = 1'b1;
                vcode_s[c] = CODE_NO_ACQ;
              end
              default: begin
                if (beat_q[c] != BEAT_MAX) beat_d[c] = beat_q[c] + W_CNT'(1);
                else                       beat_d[c] = beat_q[c];
              end
            endcase
          end
          ST_FRAG: begin
            case (kind_s[c])
              K_ACQ: begin
                if (depth_q[c] < DEPTH_MAX) begin
                  depth_d[c]    = depth_q[c] + DEPTH_ONE;
                  acq_frag_d[c] = 1'b1;
                end else begin
                  viol_s[c]  = 1'b1;
                  vcode_s[c] = CODE_DEPTH;
                end
              end
              K_RLS_FRAG: begin
                rls_frag_d[c] = 1'b1;
                depth_d[c]    = depth_q[c] - DEPTH_ONE;
                if (depth_q[c] == DEPTH_ONE) state_d[c] = ST_MSG;
                else                         state_d[c] = ST_FRAG;
              end
              K_RLS_MSG: begin
                // Releasing the message with fragments still open is an abort.
                state_d[c]   = ST_IDLE;
                depth_d[c]   = '0;
                rls_msg_d[c] = 1'b1;
                viol_s[c]    = 1'b1;
                vcode_s[c]   = CODE_NO_ACQ;
              end
              default: begin
                if (beat_q[c] != BEAT_MAX) beat_d[c] = beat_q[c] + W_CNT'(1);
                else                       beat_d[c] = beat_q[c];
              end
            endcase
          end
          default: begin
            state_d[c] = ST_IDLE;
            depth_d[c] = '0;
          end
        endcase
      end else begin
`ifdef TOKEN_TIMEOUT_EN
        if (state_q[c] != ST_IDLE) begin
          if (idle_q[c] == TO_LAST) begin
            state_d[c]   = ST_IDLE;
            depth_d[c]   = '0;
            rls_msg_d[c] = 1'b1;
            viol_s[c]    = 1'b1;
            vcode_s[c]   = CODE_OUTSIDE;
          end else begin
            idle_d[c] = idle_q[c] + W_TO'(1);
          end
        end else begin
          idle_d[c] = '0;
        end
`else
        state_d[c] = state_q[c];
`endif
      end

      // A new violation beats a same-cycle clear; otherwise the first cause sticks.
      if (viol_s[c] && (!err_q[c] || bus.I_err_clr[c])) begin
        err_d[c]  = 1'b1;
        code_d[c] = vcode_s[c];
      end else if (bus.I_err_clr[c]) begin
        err_d[c]  = 1'b0;
        code_d[c] = CODE_NONE;
      end else begin
        err_d[c]  = err_q[c];
        code_d[c] = code_q[c];
      end

      busy_d[c] = (state_d[c] != ST_IDLE);
      frag_d[c] = (state_d[c] == ST_FRAG);
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= ST_IDLE;
        depth_q[c] <= '0;
        beat_q[c]  <= '0;
        code_q[c]  <= CODE_NONE;
`ifdef TOKEN_TIMEOUT_EN
        idle_q[c]  <= '0;
`endif
      end
      busy_q     <= '0;
      frag_q     <= '0;
      acq_msg_q  <= '0;
      rls_msg_q  <= '0;
      acq_frag_q <= '0;
      rls_frag_q <= '0;
      err_q      <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        depth_q[c] <= depth_d[c];
        beat_q[c]  <= beat_d[c];
        code_q[c]  <= code_d[c];
`ifdef TOKEN_TIMEOUT_EN
        idle_q[c]  <= idle_d[c];
`endif
      end
      busy_q     <= busy_d;
      frag_q     <= frag_d;
      acq_msg_q  <= acq_msg_d;
      rls_msg_q  <= rls_msg_d;
      acq_frag_q <= acq_frag_d;
      rls_frag_q <= rls_frag_d;
      err_q      <= err_d;
    end
  end

  assign bus.O_busy        = busy_q;
  assign bus.O_in_frag     = frag_q;
  assign bus.O_acq_message = acq_msg_q;
  assign bus.O_rls_message = rls_msg_q;
  assign bus.O_acq_flagmsg = acq_frag_q;
  assign bus.O_rls_flagmsg = rls_frag_q;
  assign bus.O_err         = err_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign bus.O_frag_depth[c] = depth_q[c];
    assign bus.O_beat_cnt[c]   = beat_q[c];
    assign bus.O_err_code[c]   = code_q[c];
  end

endmodule

// File: tb/tb_token_tracker.sv
// Directed bench for token_tracker: a vector table for the main flows plus hand-written
// sequences for beat saturation, error override, mid-message reset and idle timeout.
module tb_token_tracker;

  localparam int NUM_CH  = 4;
  localparam int W_DEPTH = 2;
  localparam int W_CNT   = 4;

  localparam logic [2:0] I  = 3'b000;
  localparam logic [2:0] A  = 3'b110;
  localparam logic [2:0] RM = 3'b111;
  localparam logic [2:0] RF = 3'b101;
  localparam logic [2:0] D  = 3'b100;

  typedef struct {
    logic [11:0] tok;
    logic [3:0]  clr;
    logic [3:0]  busy;
    logic [3:0]  frag;
    logic [7:0]  depth;
    logic [15:0] beat;
    logic [3:0]  am;
    logic [3:0]  rm;
    logic [3:0]  af;
    logic [3:0]  rf;
    logic [3:0]  err;
    logic [7:0]  code;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  vec_t vq[$];

  token_tracker_if #(.NUM_CH(NUM_CH), .W_DEPTH(W_DEPTH), .W_CNT(W_CNT)) tif ();

  token_tracker #(
    .NUM_CH(NUM_CH), .MAX_FRAG_DEPTH(3), .W_DEPTH(W_DEPTH), .W_CNT(W_CNT), .TIMEOUT(8)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [11:0] tok, input logic [3:0] clr);
    for (int c = 0; c < NUM_CH; c++) tif.I_FTk[c] = tok[c*3 +: 3];
    tif.I_err_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [11:0] tok, input logic [3:0] clr, input logic [3:0] busy,
                     input logic [3:0] frag, input logic [7:0] depth, input logic [15:0] beat,
                     input logic [3:0] am, input logic [3:0] rm, input logic [3:0] af,
                     input logic [3:0] rf, input logic [3:0] err, input logic [7:0] code);
    vq.push_back('{tok, clr, busy, frag, depth, beat, am, rm, af, rf, err, code});
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, " busy"},   tif.O_busy,       v.busy);
    chk({tag, " frag"},   tif.O_in_frag,    v.frag);
    chk({tag, " depth"},  tif.O_frag_depth, v.depth);
    chk({tag, " beat"},   tif.O_beat_cnt,   v.beat);
    chk({tag, " pulses"}, {tif.O_acq_message, tif.O_rls_message, tif.O_acq_flagmsg, tif.O_rls_flagmsg},
        {v.am, v.rm, v.af, v.rf});
    chk({tag, " err"},    tif.O_err,        v.err);
    chk({tag, " code"},   tif.O_err_code,   v.code);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t zero;
    n_cmp = 0;
    n_err = 0;
    zero  = '{12'h000, 4'h0, 4'h0, 4'h0, 8'h00, 16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00};

    // ch0: acquire, 5 beats, release
    add({I,I,I,A},  4'h0, 4'b0001, 4'h0, 8'h00, 16'h0000, 4'b0001, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    add({I,I,I,D},  4'h0, 4'b0001, 4'h0, 8'h00, 16'h0001, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    add({I,I,I,D},  4'h0, 4'b0001, 4'h0, 8'h00, 16'h0002, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    add({I,I,I,D},  4'h0, 4'b0001, 4'h0, 8'h00, 16'h0003, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    add({I,I,I,D},  4'h0, 4'b0001, 4'h0, 8'h00, 16'h0004, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    add({I,I,I,D},  4'h0, 4'b0001, 4'h0, 8'h00, 16'h0005, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    add({I,I,I,RM}, 4'h0, 4'b0000, 4'h0, 8'h00, 16'h0005, 4'h0, 4'b0001, 4'h0, 4'h0, 4'h0, 8'h00);
    // ch1: nest to max depth, overflow, unwind
    add({I,I,A,I},  4'h0, 4'b0010, 4'h0,    8'h00, 16'h0005, 4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    add({I,I,A,I},  4'h0, 4'b0010, 4'b0010, 8'h04, 16'h0005, 4'h0, 4'h0, 4'b0010, 4'h0, 4'h0, 8'h00);
    add({I,I,A,I},  4'h0, 4'b0010, 4'b0010, 8'h08, 16'h0005, 4'h0, 4'h0, 4'b0010, 4'h0, 4'h0, 8'h00);
    add({I,I,A,I},  4'h0, 4'b0010, 4'b0010, 8'h0C, 16'h0005, 4'h0, 4'h0, 4'b0010, 4'h0, 4'h0, 8'h00);
    add({I,I,A,I},  4'h0, 4'b0010, 4'b0010, 8'h0C, 16'h0005, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0010, 8'h08);
    add({I,I,RF,I}, 4'h0, 4'b0010, 4'b0010, 8'h08, 16'h0005, 4'h0, 4'h0, 4'h0, 4'b0010, 4'b0010, 8'h08);
    add({I,I,RF,I}, 4'h0, 4'b0010, 4'b0010, 8'h04, 16'h0005, 4'h0, 4'h0, 4'h0, 4'b0010, 4'b0010, 8'h08);
    add({I,I,RF,I}, 4'h0, 4'b0010, 4'h0,    8'h00, 16'h0005, 4'h0, 4'h0, 4'h0, 4'b0010, 4'b0010, 8'h08);
    add({I,I,RM,I}, 4'h0, 4'b0000, 4'h0,    8'h00, 16'h0005, 4'h0, 4'b0010, 4'h0, 4'h0, 4'b0010, 8'h08);
    add({I,I,I,I},  4'b0010, 4'h0, 4'h0,    8'h00, 16'h0005, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    // ch2: errors while idle, sticky code, clear, clear+violation
    add({I,RF,I,I}, 4'h0,    4'h0, 4'h0, 8'h00, 16'h0005, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0100, 8'h10);
    add({I,D,I,I},  4'h0,    4'h0, 4'h0, 8'h00, 16'h0005, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0100, 8'h10);
    add({I,I,I,I},  4'b0100, 4'h0, 4'h0, 8'h00, 16'h0005, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,    8'h00);
    add({I,D,I,I},  4'b0100, 4'h0, 4'h0, 8'h00, 16'h0005, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0100, 8'h30);
    add({I,I,I,I},  4'b0100, 4'h0, 4'h0, 8'h00, 16'h0005, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,    8'h00);
    // all channels together; ch3 aborts from depth 1
    add({A,A,A,A},    4'h0, 4'b1111, 4'h0,    8'h00, 16'h0000, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    add({A,I,I,I},    4'h0, 4'b1111, 4'b1000, 8'h40, 16'h0000, 4'h0, 4'h0, 4'b1000, 4'h0, 4'h0, 8'h00);
    add({RM,I,I,I},   4'h0, 4'b0111, 4'h0,    8'h00, 16'h0000, 4'h0, 4'b1000, 4'h0, 4'h0, 4'b1000, 8'h40);
    add({I,D,D,D},    4'h0, 4'b0111, 4'h0,    8'h00, 16'h0111, 4'h0, 4'h0, 4'h0, 4'h0, 4'b1000, 8'h40);
    add({I,RM,RM,RM}, 4'h0, 4'b0000, 4'h0,    8'h00, 16'h0111, 4'h0, 4'b0111, 4'h0, 4'h0, 4'b1000, 8'h40);
    add({I,I,I,I},    4'b1000, 4'h0, 4'h0,    8'h00, 16'h0111, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    rst_n = 1'b0;
    drive(12'h000, 4'h0);
    step();
    step();
    check_all("reset", zero);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].tok, vq[i].clr);
      step();
      check_all($sformatf("v%0d", i), vq[i]);
    end

    // beat counter saturates instead of wrapping
    drive({I,I,I,A}, 4'h0); step();
    drive({I,I,I,D}, 4'h0);
    for (int i = 0; i < 20; i++) step();
    chk("sat beat0", tif.O_beat_cnt[0], 4'hF);
    chk("sat err0",  tif.O_err[0], 1'b0);
    drive({I,I,I,RM}, 4'h0); step();
    chk("sat rls busy0", tif.O_busy[0], 1'b0);
    chk("sat hold beat0", tif.O_beat_cnt[0], 4'hF);

    // violation with clear while already in error replaces the code
    drive({I,RF,I,I}, 4'h0); step();
    chk("ovr code2 first", tif.O_err_code[2], 2'd1);
    drive({I,D,I,I}, 4'b0100); step();
    chk("ovr err2", tif.O_err[2], 1'b1);
    chk("ovr code2 new", tif.O_err_code[2], 2'd3);
    drive({I,I,I,I}, 4'b0100); step();
    chk("ovr clr err2", tif.O_err[2], 1'b0);

    // asynchronous reset in the middle of a nested message
    drive({I,I,I,A}, 4'h0); step(); step(); step();
    chk("mid depth0", tif.O_frag_depth[0], 2'd2);
    drive({I,I,I,I}, 4'h0);
    rst_n = 1'b0;
    #1;
    chk("rst busy",  tif.O_busy, 4'h0);
    chk("rst frag",  tif.O_in_frag, 4'h0);
    chk("rst depth", tif.O_frag_depth, 8'h00);
    chk("rst beat",  tif.O_beat_cnt, 16'h0000);
    chk("rst pulses", {tif.O_acq_message, tif.O_rls_message, tif.O_acq_flagmsg, tif.O_rls_flagmsg}, 16'h0000);
    chk("rst err",   {tif.O_err, tif.O_err_code}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    drive({I,I,I,A}, 4'h0); step();
    chk("post rst acq", tif.O_acq_message, 4'b0001);
    chk("post rst busy", tif.O_busy, 4'b0001);
    chk("post rst frag", tif.O_in_frag, 4'b0000);
    drive({I,I,I,RM}, 4'h0); step();
    drive({I,I,I,I}, 4'h0);

`ifdef TOKEN_TIMEOUT_EN
    drive({I,I,I,A}, 4'h0); step();
    drive({I,I,I,I}, 4'h0);
    for (int i = 0; i < 7; i++) step();
    chk("to busy at 7", tif.O_busy[0], 1'b1);
    step();
    chk("to busy at 8", tif.O_busy[0], 1'b0);
    chk("to rls pulse", tif.O_rls_message[0], 1'b1);
    chk("to err", {tif.O_err[0], tif.O_err_code[0]}, 3'b111);
    drive({I,I,I,I}, 4'b0001); step();
    drive({I,I,I,A}, 4'h0); step();
    drive({I,I,I,I}, 4'h0);
    for (int i = 0; i < 6; i++) step();
    drive({I,I,I,D}, 4'h0); step();
    drive({I,I,I,I}, 4'h0);
    for (int i = 0; i < 7; i++) step();
    chk("no to busy", tif.O_busy[0], 1'b1);
    chk("no to err", tif.O_err[0], 1'b0);
    drive({I,I,I,RM}, 4'h0); step();
    chk("no to rls", tif.O_rls_message[0], 1'b1);
    drive({I,I,I,I}, 4'h0);
`else
    drive({I,I,I,A}, 4'h0); step();
    drive({I,I,I,I}, 4'h0);
    for (int i = 0; i < 30; i++) step();
    chk("hold busy", tif.O_busy[0], 1'b1);
    chk("hold err", tif.O_err[0], 1'b0);
    drive({I,I,I,RM}, 4'h0); step();
    chk("hold rls", tif.O_rls_message[0], 1'b1);
    drive({I,I,I,I}, 4'h0);
`endif
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
